// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer -- programmable up-counting timer with a done flag.
//
// Counts rising clock edges on which enable is sampled high. Once LIMIT such
// edges have elapsed, done is raised. Dropping enable clears the timer
// synchronously, so every new run starts from zero.
//
// Configuration macro: TIMER_AUTO_RELOAD_EN
//   undefined (default): one-shot. count saturates at LIMIT and done is a
//                        level held until enable falls.
//   defined            : periodic. count runs 0..LIMIT-1 and done is a
//                        one-cycle pulse every LIMIT enabled edges.
//
// Parameters:
//   LIMIT : enabled edges before done asserts (must be >= 1)
//   CW    : counter width, derived from LIMIT (do not override)
//
// Ports:
//   clk    : system clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   enable : high runs/holds the timer, low clears it
//   done   : registered done flag
//   count  : registered elapsed-cycle count
// -----------------------------------------------------------------------------
module timer #(
  parameter int LIMIT = 5,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  output logic          done,
  output logic [CW-1:0] count
);

  // Reject illegal configurations at elaboration time.
  if (LIMIT < 1) begin : g_bad_limit
    $error("timer: LIMIT must be >= 1");
  end

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          done_q;
  logic          done_d;

`ifdef TIMER_AUTO_RELOAD_EN
  // Last count value before the period wraps back to zero.
  localparam logic [CW-1:0] WRAP_C = CW'(LIMIT - 1);

  // Next-state logic, periodic mode: wrap and pulse done once per period.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    if (!enable) begin
      count_d = {CW{1'b0}};
      done_d  = 1'b0;
    end else if (count_q == WRAP_C) begin
      count_d = {CW{1'b0}};
      done_d  = 1'b1;
    end else begin
      count_d = count_q + CW'(1);
      done_d  = 1'b0;
    end
  end
`else
  // Saturation value; CW is sized so LIMIT always fits.
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  // Next-state logic, one-shot mode: count up to LIMIT and hold there.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    if (!enable) begin
      count_d = {CW{1'b0}};
      done_d  = 1'b0;
    end else if (count_q == LIMIT_C) begin
      count_d = count_q;
      done_d  = 1'b1;
    end else begin
      count_d = count_q + CW'(1);
      // done rises on the same edge at which count reaches LIMIT.
      done_d  = (count_q + CW'(1)) == LIMIT_C;
    end
  end
`endif

  // State register; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CW{1'b0}};
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_timer.sv
// -----------------------------------------------------------------------------
// tb_timer -- self-checking bench for timer.
//
// Two instances share clock, reset and enable: LIMIT=5 and LIMIT=1. A
// reference model predicts count/done for each after every edge; predictions
// are queued when enable is driven and compared after the edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer;

  localparam int L5  = 5;
  localparam int L1  = 1;
  localparam int CW5 = $clog2(L5 + 1);
  localparam int CW1 = $clog2(L1 + 1);

  logic           clk;
  logic           rst_n;
  logic           enable;
  logic           done5;
  logic           done1;
  logic [CW5-1:0] count5;
  logic [CW1-1:0] count1;

  typedef struct {
    int c5;
    int d5;
    int c1;
    int d1;
  } exp_t;

  exp_t sb_q[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  int m_c5 = 0;
  int m_d5 = 0;
  int m_c1 = 0;
  int m_d1 = 0;

  timer #(.LIMIT(L5)) dut5 (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .done   (done5),
    .count  (count5)
  );

  timer #(.LIMIT(L1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .done   (done1),
    .count  (count1)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_total++;
    if (obs == exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One model step for a timer of limit lim.
  task automatic model_next(input int lim, input logic en, inout int c, inout int d);
`ifdef TIMER_AUTO_RELOAD_EN
    if (!en) begin
      c = 0; d = 0;
    end else if (c == lim - 1) begin
      c = 0; d = 1;
    end else begin
      c = c + 1; d = 0;
    end
`else
    if (!en) begin
      c = 0;
    end else if (c < lim) begin
      c = c + 1;
    end
    d = (en && c == lim) ? 1 : 0;
`endif
  endtask

  // Drive enable for one edge, predict, then compare after the edge.
  task automatic step(input logic en);
    exp_t e;
    exp_t got;
    enable = en;
    #1;
    // done is registered: changing enable must not move it before the edge.
    check_eq("hold_done5", int'(done5), m_d5);
    check_eq("hold_done1", int'(done1), m_d1);
    model_next(L5, en, m_c5, m_d5);
    model_next(L1, en, m_c1, m_d1);
    e.c5 = m_c5; e.d5 = m_d5; e.c1 = m_c1; e.d1 = m_d1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      check_eq("count5", int'(count5), got.c5);
      check_eq("done5",  int'(done5),  got.d5);
      check_eq("count1", int'(count1), got.c1);
      check_eq("done1",  int'(done1),  got.d1);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_count5"}, int'(count5), 0);
    check_eq({tag, "_done5"},  int'(done5),  0);
    check_eq({tag, "_count1"}, int'(count1), 0);
    check_eq({tag, "_done1"},  int'(done1),  0);
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    check_zero("reset");
    #6;
    check_zero("reset_edge");
    #5;                       // t = 12 ns: release reset, start running
    rst_n = 1'b1;

    // Reset and start: count 1..5, done at 5th edge, then hold.
    for (int i = 0; i < 7; i++) step(1'b1);

    // Restart after done.
    for (int i = 0; i < 2; i++) step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1);

    // Mid-count abort.
    step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    for (int i = 0; i < 6; i++) step(1'b1);

    // Asynchronous reset mid-count.
    step(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    m_c5 = 0; m_d5 = 0; m_c1 = 0; m_d1 = 0;
    @(posedge clk);
    #1;
    check_zero("rst_held_edge");
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b1);

    check_eq("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
